fft_modulus_reader: RTL and testbench

Drain side of the FFT modulus FIFO: reads one frame of FRAME_LEN modulus samples out of the synchronous FIFO, which has a 1-cycle read latency and no output register. It absorbs that latency with a 2-entry skid buffer and presents the samples as a valid/ready stream with a last-beat marker. It also tracks the per-frame peak magnitude and its bin index for the spectrum display / frequency-measurement logic downstream.

---
 rtl/fft_modulus_reader_if.sv | 52 +++++
 rtl/fft_modulus_reader.sv | 166 ++++++++++++++++
 tb/tb_fft_modulus_reader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_modulus_reader_if.sv
// ---------------------------------------------------------------------------
// fft_modulus_reader_if
// Bundles the FIFO read port and the outgoing sample stream of the FFT
// modulus reader.
//
// Signals:
//   fifo_rd_en     reader -> FIFO   read enable
//   fifo_rd_data   FIFO -> reader   read data, valid the cycle after rd_en
//   fifo_rd_empty  FIFO -> reader   empty flag
//   m_data         reader -> sink   stream data
//   m_valid        reader -> sink   stream valid
//   m_ready        sink -> reader   stream ready
//   m_last         reader -> sink   last sample of the frame
//   m_idx          reader -> sink   bin index of m_data
//
// Modports: master = the reader, slave = the FIFO/sink side.
// ---------------------------------------------------------------------------
interface fft_modulus_reader_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 10
) ();
    logic                   fifo_rd_en;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic                   fifo_rd_empty;
    logic [DATA_WIDTH-1:0]  m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;
    logic [DEPTH_WIDTH-1:0] m_idx;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last,
        output m_idx
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last,
        input  m_idx
    );
endinterface

// File: rtl/fft_modulus_reader.sv
// ---------------------------------------------------------------------------
// fft_modulus_reader
// Drains one frame of FRAME_LEN modulus samples from a synchronous FIFO with
// a 1-cycle read latency, absorbs that latency in a 2-entry skid buffer and
// presents the samples as a valid/ready stream with index and last marker.
// Optionally tracks the frame peak magnitude and its bin index.
//
// Optional feature macro: FFT_RD_PEAK_EN (peak tracking; peak outputs are
// tied to 0 when undefined).
//
// Ports:
//   clk       clock shared with the FIFO
//   tb_rst    asynchronous active-high reset
//   start     single-cycle pulse, starts a frame read when idle
//   bus       fft_modulus_reader_if.master (FIFO read port + stream)
//   busy      high from start acceptance until the done pulse
//   done      1-cycle pulse the cycle after the last beat is accepted
//   peak_val  largest sample of the last completed frame
//   peak_idx  bin index of peak_val (first occurrence on ties)
// ---------------------------------------------------------------------------
module fft_modulus_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 10,
    parameter int FRAME_LEN   = 1024
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    input  logic                   start,
    fft_modulus_reader_if.master   bus,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  peak_val,
    output logic [DEPTH_WIDTH-1:0] peak_idx
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    localparam logic [DEPTH_WIDTH:0]   LP_FRAME = (DEPTH_WIDTH+1)'(FRAME_LEN);
    localparam logic [DEPTH_WIDTH-1:0] LP_LAST  = DEPTH_WIDTH'(FRAME_LEN-1);

    state_t                 r_state, w_state_nxt;
    logic [DEPTH_WIDTH:0]   r_issued;
    logic                   r_inflight;
    logic [DATA_WIDTH-1:0]  r_buf [0:1];
    logic                   r_wr_ptr, r_rd_ptr;
    logic [1:0]             r_occ;
    logic [DEPTH_WIDTH-1:0] r_idx;

    logic                   w_valid, w_pop, w_push, w_last, w_rd_en, w_start_acc;
    logic [2:0]             w_level;
    logic [DATA_WIDTH-1:0]  w_head;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_valid     = (r_occ != 2'd0);
    assign w_head      = r_buf[r_rd_ptr];
    assign w_pop       = w_valid && bus.m_ready;
    // The word requested last cycle lands in the buffer this cycle.
    assign w_push      = r_inflight;
    assign w_last      = w_valid && (r_idx == LP_LAST);

    // Words held or already requested, after this cycle's pop. Issuing only
    // when this is below 2 guarantees the in-flight word always has a slot.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = (r_state == S_READ) && !bus.fifo_rd_empty &&
                     (r_issued < LP_FRAME) && (w_level < 3'd2);

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_valid ? w_head : '0;
    assign bus.m_last     = w_last;
    assign bus.m_idx      = r_idx;
    assign busy           = (r_state == S_READ) || (r_state == S_FLUSH);
    assign done           = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_READ;
            S_READ:  if (r_issued == LP_FRAME) w_state_nxt = S_FLUSH;
            // Accepting the last beat empties the pipe; done follows at once.
            S_FLUSH: if (w_pop && w_last && !r_inflight) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state    <= S_IDLE;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            if (w_start_acc)
                r_issued <= '0;
            else if (w_rd_en)
                r_issued <= r_issued + (DEPTH_WIDTH+1)'(1);
            if (w_start_acc)
                r_idx <= '0;
            else if (w_pop)
                r_idx <= r_idx + DEPTH_WIDTH'(1);
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Buffer storage needs no reset: m_data is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push)
            r_buf[r_wr_ptr] <= bus.fifo_rd_data;
    end

`ifdef FFT_RD_PEAK_EN
    logic [DATA_WIDTH-1:0]  r_run_max, w_run_max_nxt, r_peak_val;
    logic [DEPTH_WIDTH-1:0] r_run_idx, w_run_idx_nxt, r_peak_idx;
    logic                   w_frame_end;

    assign w_frame_end = (r_state == S_FLUSH) && (w_state_nxt == S_DONE);

    // Strictly-greater update keeps the first occurrence on ties.
    always_comb begin
        w_run_max_nxt = r_run_max;
        w_run_idx_nxt = r_run_idx;
        if (w_pop && (w_head > r_run_max)) begin
            w_run_max_nxt = w_head;
            w_run_idx_nxt = r_idx;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_run_max  <= '0;
            r_run_idx  <= '0;
            r_peak_val <= '0;
            r_peak_idx <= '0;
        end else begin
            if (w_start_acc) begin
                r_run_max <= '0;
                r_run_idx <= '0;
            end else begin
                r_run_max <= w_run_max_nxt;
                r_run_idx <= w_run_idx_nxt;
            end
            // Include the final beat so the result is visible during done.
            if (w_frame_end) begin
                r_peak_val <= w_run_max_nxt;
                r_peak_idx <= w_run_idx_nxt;
            end
        end
    end

    assign peak_val = r_peak_val;
    assign peak_idx = r_peak_idx;
`else
    assign peak_val = '0;
    assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_fft_modulus_reader.sv
module tb_fft_modulus_reader;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int FL = 1024;
`ifdef FFT_RD_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          tb_rst;
    logic          start;
    logic          busy, done;
    logic [DW-1:0] peak_val;
    logic [AW-1:0] peak_idx;

    fft_modulus_reader_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bus ();

    fft_modulus_reader #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .tb_rst   (tb_rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .peak_val (peak_val),
        .peak_idx (peak_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        if (failures <= 40)
            $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    // FIFO contents, and the words read out of it but not yet accepted downstream
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_q[$];
    bit            trickle_en = 1'b0;
    int            rdy_mode = 0;
    bit            pin_desc = 1'b0;

    // Reference state of one frame
    int            beat = 0;
    bit            active = 1'b0;
    bit            done_exp = 1'b0;
    int            run_max = 0, run_idx = 0;
    int            pk_val = 0, pk_idx = 0;
    int            dut_dones = 0;

    // Synchronous FIFO: 1-cycle read latency, empty flag registered
    initial begin : fifo_model
        logic [DW-1:0] v;
        bit            rd_s;
        int            cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            rd_s = bus.fifo_rd_en;
            @(posedge clk);
            if (rd_s && q.size() > 0) begin
                v = q.pop_front();
                bus.fifo_rd_data <= v;
                exp_q.push_back(v);
            end
            if (trickle_en && (cyc % 4 == 0))
                q.push_back(DW'($urandom));
            cyc++;
            bus.fifo_rd_empty <= (q.size() == 0);
        end
    end

    // Downstream ready patterns
    initial begin : ready_gen
        int ph;
        ph = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.m_ready = (ph % 4 == 0) || (ph % 4 == 3);
                2:       bus.m_ready = ($urandom_range(0, 2) != 0);
                default: bus.m_ready = 1'b1;
            endcase
            ph++;
        end
    end

    // Compare process: checks every cycle against the frame-level model
    initial begin : monitor
        bit            pop, last_pop, nd, na;
        logic [DW-1:0] v;
        forever begin
            @(negedge clk);
            if (tb_rst) begin
                chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
                chk("rst_m_valid", 32'(bus.m_valid), 0);
                chk("rst_m_data", 32'(bus.m_data), 0);
                chk("rst_m_last", 32'(bus.m_last), 0);
                chk("rst_m_idx", 32'(bus.m_idx), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_peak_val", 32'(peak_val), 0);
                chk("rst_peak_idx", 32'(peak_idx), 0);
                exp_q.delete();
                beat = 0; active = 0; done_exp = 0;
                run_max = 0; run_idx = 0; pk_val = 0; pk_idx = 0;
            end else begin
                pop = bus.m_valid && bus.m_ready;
                if (done) dut_dones++;
                chk("busy", 32'(busy), 32'(active));
                chk("done", 32'(done), 32'(done_exp));
                chk("peak_val", 32'(peak_val), 32'(pk_val));
                chk("peak_idx", 32'(peak_idx), 32'(pk_idx));
                if (!active)
                    chk("rd_en_idle", 32'(bus.fifo_rd_en), 0);
                if (bus.fifo_rd_en) begin
                    chk("rd_en_empty", 32'(bus.fifo_rd_empty), 0);
                    chk("rd_en_level", 32'((exp_q.size() - int'(pop)) < 2), 1);
                end
                if (bus.m_valid) begin
                    if (exp_q.size() == 0)
                        fail_now("m_valid_without_data");
                    else
                        chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
                    chk("m_idx", 32'(bus.m_idx), 32'(beat));
                    chk("m_last", 32'(bus.m_last), 32'(beat == FL-1));
                    if (pin_desc && pop)
                        chk("t1_data", 32'(bus.m_data), 32'((255 - beat % 256) & 255));
                end else begin
                    chk("m_last_idle", 32'(bus.m_last), 0);
                end
                last_pop = active && pop && (beat == FL-1);
                if (pop && exp_q.size() > 0) begin
                    v = exp_q.pop_front();
                    if (int'(v) > run_max) begin
                        run_max = int'(v);
                        run_idx = beat;
                    end
                    beat++;
                end
                nd = last_pop;
                if (nd) begin
                    pk_val = PEAK_EN ? run_max : 0;
                    pk_idx = PEAK_EN ? run_idx : 0;
                end
                na = active ? !last_pop : (!done_exp && start);
                if (!active && !done_exp && start) begin
                    beat = 0; run_max = 0; run_idx = 0;
                end
                done_exp = nd;
                active = na;
            end
        end
    end

    task automatic preload_desc();
        for (int i = 0; i < FL; i++)
            q.push_back(DW'(255 - i % 256));
    endtask

    task automatic preload_rand();
        for (int i = 0; i < FL; i++)
            q.push_back(DW'($urandom));
    endtask

    task automatic run_frame(input int budget, input bit poke);
        int n, d0;
        d0 = dut_dones;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > budget) begin
                fail_now("done_timeout");
                break;
            end
            @(posedge clk); #1 start = poke && ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1 start = 1'b0;
        chk("frame_count", 32'(dut_dones - d0), 1);
    endtask

    initial begin : stim
        int n, c;
        tb_rst = 1'b1;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        #1 tb_rst = 1'b0;

        // Descending preload, ready held high: latency, throughput, tie on peak
        preload_desc();
        pin_desc = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        chk("t1_valid_at_start", 32'(bus.m_valid), 0);
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        while (1) begin
            @(negedge clk);
            if (bus.m_valid || n > 10) break;
            n++;
        end
        chk("t1_first_valid_cycle", 32'(n), 3);
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            if (done || c > 3000) break;
        end
        chk("t1_done_cycle", 32'(c), 1024);
        chk("t1_peak_val", 32'(peak_val), PEAK_EN ? 255 : 0);
        chk("t1_peak_idx", 32'(peak_idx), 0);
        chk("t1_busy_in_done", 32'(busy), 0);
        pin_desc = 1'b0;
        @(posedge clk); #1;
        chk("t1_fifo_drained", 32'(q.size()), 0);

        // Ready toggling 1,0,0,1
        preload_desc();
        rdy_mode = 1;
        run_frame(4000, 1'b0);
        chk("t2_fifo_drained", 32'(q.size()), 0);

        // Empty FIFO at start, one write every 4 cycles, random ready
        rdy_mode = 2;
        trickle_en = 1'b1;
        run_frame(6000, 1'b0);
        trickle_en = 1'b0;
        @(posedge clk); #1 q.delete();
        repeat (2) @(posedge clk);

        // Single dominant sample at bin 9
        for (int i = 0; i < FL; i++)
            q.push_back((i == 9) ? DW'(200) : DW'(10));
        run_frame(4000, 1'b0);
        chk("t4_peak_val", 32'(peak_val), PEAK_EN ? 200 : 0);
        chk("t4_peak_idx", 32'(peak_idx), PEAK_EN ? 9 : 0);

        // start pulsed while busy must be ignored
        preload_rand();
        run_frame(4000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_extra_frame", 32'(busy), 0);
        chk("t5_fifo_drained", 32'(q.size()), 0);

        // Reset in the middle of a frame, then a fresh frame from the FIFO head
        preload_desc();
        rdy_mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (beat < 500 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_beat_500", 32'(beat >= 500), 1);
        @(posedge clk); #1 tb_rst = 1'b1;
        #1;
        chk("t6_async_m_valid", 32'(bus.m_valid), 0);
        chk("t6_async_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_m_idx", 32'(bus.m_idx), 0);
        repeat (2) @(posedge clk);
        #1 tb_rst = 1'b0;
        preload_rand();
        rdy_mode = 2;
        run_frame(5000, 1'b0);
        chk("t6_peak_idx_range", 32'(int'(peak_idx) < FL), 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
